// File: rtl/aes_subshift_iter.sv
// Iterative AES SubBytes + ShiftRows stage feeding MixColumns.
// BYTES_PER_CYCLE shared S-boxes walk the state chunk by chunk; ShiftRows is fixed wiring on the output.
module aes_subshift_iter #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam int NCHUNK = 16 / BYTES_PER_CYCLE;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

  if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
        BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
    $error("aes_subshift_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  // FIPS-197 forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8*b -: 8];
  endfunction

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [127:0]    data_q, data_d;
  logic [4:0]      base;
  logic [7:0]      sb_in  [BYTES_PER_CYCLE];
  logic [7:0]      sb_out [BYTES_PER_CYCLE];

  assign base = 5'(cnt_q) * 5'(BYTES_PER_CYCLE);

  always_comb begin
    for (int i = 0; i < BYTES_PER_CYCLE; i++) begin
      sb_in[i]  = data_q[127 - 8*(base + i) -: 8];
      sb_out[i] = sbox(sb_in[i]);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d  = in_data;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int i = 0; i < BYTES_PER_CYCLE; i++) begin
          data_d[127 - 8*(base + i) -: 8] = sb_out[i];
        end
        if (cnt_q == LAST_CHUNK) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  // ShiftRows: output row r, column c comes from row r, column (c+r) mod 4.
  for (genvar k = 0; k < 16; k++) begin : g_shift_rows
    localparam int R   = k % 4;
    localparam int C   = k / 4;
    localparam int SRC = ((C + R) % 4) * 4 + R;
    assign out_data[127 - 8*k -: 8] = data_q[127 - 8*SRC -: 8];
  end

endmodule

// File: tb/tb_aes_subshift_iter.sv
// Bench for aes_subshift_iter: BPC=4 instance exercised fully, BPC=1/2/8/16 instances on the FIPS vector.
module tb_aes_subshift_iter;

  localparam logic [127:0] FIPS_IN  = 128'h193de3be_a0f4e22b_9ac68d2a_e9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] ALL_63   = {16{8'h63}};
  localparam logic [127:0] ALL_16   = {16{8'h16}};
  localparam logic [127:0] ALL_FF   = {16{8'hff}};
  localparam int           NLAT     = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, out_ready;
  logic [127:0] in_data;
  wire          in_ready, out_valid;
  wire  [127:0] out_data;

  logic [3:0]   a_in_valid;
  logic [127:0] a_in_data;
  wire  [3:0]   a_in_ready, a_out_valid;
  wire  [127:0] a_out_data [4];

  int tests = 0;
  int errs  = 0;
  logic [7:0] sb_ref [256];

  always #5 clk = ~clk;

  aes_subshift_iter #(.BYTES_PER_CYCLE(4)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  for (genvar g = 0; g < 4; g++) begin : g_alt
    aes_subshift_iter #(.BYTES_PER_CYCLE((g < 2) ? (1 << g) : (1 << (g + 1)))) u_alt (
      .clk(clk), .rst(rst),
      .in_valid(a_in_valid[g]), .in_ready(a_in_ready[g]), .in_data(a_in_data),
      .out_valid(a_out_valid[g]), .out_ready(1'b1), .out_data(a_out_data[g])
    );
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference S-box built from GF(2^8) inversion and the affine map.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h00;
    for (int b = 1; b < 256; b++)
      if (gf_mul(a, 8'(b)) == 8'h01) r = 8'(b);
    return r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    logic [7:0] s, r;
    s = b ^ 8'h63;
    r = b;
    for (int n = 1; n <= 4; n++) begin
      r = {r[6:0], r[7]};
      s = s ^ r;
    end
    return s;
  endfunction

  function automatic logic [127:0] ref_subshift(input logic [127:0] x);
    logic [127:0] y;
    int r, c, src;
    y = '0;
    for (int k = 0; k < 16; k++) begin
      r   = k % 4;
      c   = k / 4;
      src = ((c + r) % 4) * 4 + r;
      y[127 - 8*k -: 8] = sb_ref[x[127 - 8*src -: 8]];
    end
    return y;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send_and_check(input logic [127:0] blk, input logic [127:0] exp, input string tag);
    int lat;
    in_valid = 1'b1;
    in_data  = blk;
    tick();
    in_valid = 1'b0;
    in_data  = rand128();
    lat = 0;
    while (!out_valid && lat < 64) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, 128'(lat), 128'(NLAT));
    chk({tag, "_data"}, out_data, exp);
    tick();
    chk({tag, "_vld_drop"}, 128'(out_valid), 128'(0));
    chk({tag, "_rdy_back"}, 128'(in_ready), 128'(1));
  endtask

  task automatic run_alt(input int j);
    int bpc, lat;
    bpc = (j < 2) ? (1 << j) : (1 << (j + 1));
    a_in_data     = FIPS_IN;
    a_in_valid[j] = 1'b1;
    tick();
    a_in_valid[j] = 1'b0;
    a_in_data     = rand128();
    lat = 0;
    while (!a_out_valid[j] && lat < 64) begin
      tick();
      lat++;
    end
    chk($sformatf("alt_bpc%0d_lat", bpc), 128'(lat), 128'(16 / bpc));
    chk($sformatf("alt_bpc%0d_data", bpc), a_out_data[j], FIPS_OUT);
    tick();
    chk($sformatf("alt_bpc%0d_rdy", bpc), 128'(a_in_ready[j]), 128'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] blk, held;
    logic [127:0] sblk [8];
    int lat, sent, recv, last;
    logic acc;

    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b1;
    a_in_valid = '0;
    a_in_data  = '0;
    for (int a = 0; a < 256; a++) sb_ref[a] = affine(gf_inv(8'(a)));

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data", out_data, 128'(0));
    rst = 1'b0;
    tick();

    send_and_check('0, ALL_63, "zero");
    send_and_check(FIPS_IN, FIPS_OUT, "fips");
    for (int t = 0; t < 4; t++) begin
      blk = rand128();
      send_and_check(blk, ref_subshift(blk), $sformatf("rand%0d", t));
    end

    // Backpressure: result must hold still while out_ready is low.
    out_ready = 1'b0;
    blk = rand128();
    in_valid = 1'b1;
    in_data  = blk;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 64) begin
      tick();
      lat++;
    end
    chk("bp_lat", 128'(lat), 128'(NLAT));
    held = out_data;
    chk("bp_data", held, ref_subshift(blk));
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("bp_hold_vld", 128'(out_valid), 128'(1));
      chk("bp_hold_data", out_data, held);
      chk("bp_hold_rdy", 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release_vld", 128'(out_valid), 128'(0));
    chk("bp_release_rdy", 128'(in_ready), 128'(1));

    // in_valid held high with all-ones data while busy.
    blk = rand128();
    in_valid = 1'b1;
    in_data  = blk;
    tick();
    in_data = ALL_FF;
    lat = 0;
    while (!out_valid && lat < 64) begin
      tick();
      lat++;
    end
    chk("busy_ign_lat", 128'(lat), 128'(NLAT));
    chk("busy_ign_data", out_data, ref_subshift(blk));
    tick();
    chk("busy_ign_rdy", 128'(in_ready), 128'(1));
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 64) begin
      tick();
      lat++;
    end
    chk("second_lat", 128'(lat), 128'(NLAT));
    chk("second_data", out_data, ALL_16);
    tick();

    // Asynchronous reset in the second BUSY cycle.
    in_valid = 1'b1;
    in_data  = rand128();
    tick();
    in_valid = 1'b0;
    tick();
    #3 rst = 1'b1;
    #1;
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_out_data", out_data, 128'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    send_and_check('0, ALL_63, "post_rst");

    // Streaming with in_valid held high.
    for (int b = 0; b < 8; b++) sblk[b] = rand128();
    sent = 0;
    recv = 0;
    last = -1;
    in_valid = 1'b1;
    in_data  = sblk[0];
    for (int cyc = 0; cyc < 300 && recv < 8; cyc++) begin
      if (out_valid) begin
        chk($sformatf("stream%0d_data", recv), out_data, ref_subshift(sblk[recv]));
        if (last >= 0) chk($sformatf("stream%0d_gap", recv), 128'(cyc - last), 128'(NLAT + 2));
        last = cyc;
        recv++;
      end
      acc = in_ready && in_valid;
      tick();
      if (acc) begin
        sent++;
        if (sent < 8) in_data = sblk[sent];
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("stream_recv", 128'(recv), 128'(8));
    chk("stream_sent", 128'(sent), 128'(8));
    tick();
    tick();

    for (int j = 0; j < 4; j++) run_alt(j);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule

// File: doc/aes_subshift_iter.md
Name: aes_subshift_iter

Overview:
- Iterative AES SubBytes + ShiftRows stage for the Haraka-S AES round datapath.
- Sits directly upstream of the MixColumns stage and produces its 128-bit input state.
- Substitutes BYTES_PER_CYCLE bytes per clock through shared S-box instances, then applies ShiftRows.
- Valid/ready handshakes on both sides.

Parameters:
- BYTES_PER_CYCLE, 4: S-box instances and bytes substituted per BUSY cycle. Legal values are 1, 2, 4, 8, 16; any other value is an elaboration error.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a state
- in_data  input  128  AES state
- out_valid  output  1  out_data is valid
- out_ready  input  1  downstream (MixColumns) accepts
- out_data  output  128  ShiftRows(SubBytes(in_data))

Behaviour:
- Byte layout:
  - Byte k (0..15) occupies bits [127-8k -: 8].
  - Row = k mod 4, column = k div 4 (AES column-major), identical to the MixColumns stage layout.
- Reset: one clock, asynchronous, active-high.
  - Asserting rst forces FSM=IDLE, chunk counter=0, and the state register to 0.
  - Output reset values: in_ready=1, out_valid=0, out_data=0.
  - Reset asserted mid-operation aborts the block in flight; no partial result is ever presented.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: load in_data into the state register, clear the counter, go to BUSY.
- BUSY:
  - in_ready=0; in_valid is ignored and in_data is not sampled.
  - Each clock replaces bytes [cnt*BPC .. cnt*BPC+BPC-1] with S(byte), using the FIPS-197 forward S-box as a 256-entry constant table.
  - Counter increments by one each clock.
  - After chunk 16/BPC-1 is written, go to DONE.
- DONE:
  - out_valid=1.
  - out_data = ShiftRows(state register): output row r, column c = substituted row r, column (c+r) mod 4. This is pure rewiring from a register, so it is glitch-free and stable.
  - Hold while out_ready=0; out_data must not change while out_valid=1.
  - On out_valid&&out_ready, go to IDLE; in_ready rises the following cycle.
- Latency:
  - out_valid rises exactly 16/BPC clocks after the accepting edge (BPC=4: 4 clocks; BPC=16: 1 clock).
  - Throughput is one block per 16/BPC+2 clocks when out_ready is held high.
- Counter width: clog2(16/BPC), minimum 1 bit. It wraps to 0 on leaving BUSY.
- No combinational path from in_valid to in_ready.
- No combinational path from out_ready to out_valid or out_data.
- in_data may change freely after the accepting edge.

Test Plan:
- All-zero state, BPC=4:
  - in_data=0, in_valid pulsed in IDLE -> out_valid after 4 clocks, out_data=0x63636363_63636363_63636363_63636363.
- FIPS-197 round-1 vector:
  - in_data=193de3be_a0f4e22b_9ac68d2a_e9f84808 -> out_data=d4bf5d30_e0b452ae_b84111f1_1e2798e5.
  - Repeat for BPC=1, 2, 8, 16; required latency is 16, 8, 2, 1 clocks respectively.
- Backpressure:
  - Hold out_ready=0 for 10 clocks after out_valid rises -> out_valid stays 1, out_data is constant, in_ready stays 0.
  - Assert out_ready -> out_valid falls next clock, in_ready=1.
- Input ignored while busy:
  - Drive in_valid=1 with in_data=ffff...ff during BUSY -> result still matches the first accepted block.
  - Second block is accepted only after returning to IDLE; its output is 0x1616...16.
- Reset mid-operation:
  - Assert rst asynchronously (off clock edge) in the 2nd BUSY cycle -> in_ready=1, out_valid=0, out_data=0 immediately.
  - Next accepted block (in_data=0) yields all-0x63 with nominal latency.
- Back-to-back streaming, out_ready=1:
  - 8 random blocks with in_valid held high -> outputs match a reference model in order.
  - Spacing is 16/BPC+2 clocks per block; no block is dropped or duplicated.
